// File: rtl/vga_dither_if.sv
// ============================================================================
// Module      : vga_dither_if
// Description : Pixel stream bundle between the game core and the dither stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_dither_if;
    logic       IN_HSYNC;
    logic       IN_VSYNC;
    logic [7:0] IN_RED;
    logic [7:0] IN_GREEN;
    logic [7:0] IN_BLUE;
    logic       VGA_HSYNC;
    logic       VGA_VSYNC;
    logic [3:0] VGA_RED;
    logic [3:0] VGA_GREEN;
    logic [3:0] VGA_BLUE;

    // Game core side: produces the 8-bit stream, observes the DAC drive.
    modport master (
        output IN_HSYNC, IN_VSYNC, IN_RED, IN_GREEN, IN_BLUE,
        input  VGA_HSYNC, VGA_VSYNC, VGA_RED, VGA_GREEN, VGA_BLUE
    );

    // Dither stage side.
    modport slave (
        input  IN_HSYNC, IN_VSYNC, IN_RED, IN_GREEN, IN_BLUE,
        output VGA_HSYNC, VGA_VSYNC, VGA_RED, VGA_GREEN, VGA_BLUE
    );
endinterface

`default_nettype wire

// File: rtl/vga_dither.sv
// ============================================================================
// Module      : vga_dither
// Description : 8-bit to 4-bit per channel VGA output stage with 4x4 Bayer
//               ordered dither. Dithering enabled by macro VGA_DITHER_EN;
//               otherwise plain truncation with identical 2-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_dither #(
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  wire logic   CLK_25MHZ,
    input  wire logic   RESET,
    vga_dither_if.slave bus
);

    localparam logic c_SYNC_IDLE = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;

    // Saturating add of the threshold, then keep the top nibble.
    function automatic logic [3:0] sat_trunc(input logic [7:0] c, input logic [3:0] t);
        logic [8:0] s;
        s = {1'b0, c} + {5'b0_0000, t};
        return s[8] ? 4'hF : s[7:4];
    endfunction

    logic [3:0] w_thresh;

`ifdef VGA_DITHER_EN
    function automatic logic [3:0] bayer4(input logic [1:0] yy, input logic [1:0] xx);
        logic [3:0] t;
        case ({yy, xx})
            4'b00_00: t = 4'd0;
            4'b00_01: t = 4'd8;
            4'b00_10: t = 4'd2;
            4'b00_11: t = 4'd10;
            4'b01_00: t = 4'd12;
            4'b01_01: t = 4'd4;
            4'b01_10: t = 4'd14;
            4'b01_11: t = 4'd6;
            4'b10_00: t = 4'd3;
            4'b10_01: t = 4'd11;
            4'b10_10: t = 4'd1;
            4'b10_11: t = 4'd9;
            4'b11_00: t = 4'd15;
            4'b11_01: t = 4'd7;
            4'b11_10: t = 4'd13;
            default:  t = 4'd5;
        endcase
        return t;
    endfunction

    logic       r_hs_prev;
    logic       r_vs_prev;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       w_hs_start;
    logic       w_vs_start;
    logic [9:0] w_x;
    logic [9:0] w_y;

    assign w_hs_start = (bus.IN_HSYNC != c_SYNC_IDLE) && (r_hs_prev == c_SYNC_IDLE);
    assign w_vs_start = (bus.IN_VSYNC != c_SYNC_IDLE) && (r_vs_prev == c_SYNC_IDLE);

    // Position of the pixel being sampled this cycle; a sync start applies to
    // this very pixel, so the first pixel of a line sees x = 0.
    assign w_x = w_hs_start ? 10'd0 : r_x;

    always_comb begin
        w_y = r_y;
        if (w_vs_start) begin
            w_y = 10'd0;
        end else if (w_hs_start) begin
            w_y = r_y + 10'd1;
        end
    end

    assign w_thresh = bayer4(w_y[1:0], w_x[1:0]);

    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            r_hs_prev <= c_SYNC_IDLE;
            r_vs_prev <= c_SYNC_IDLE;
            r_x       <= 10'd0;
            r_y       <= 10'd0;
        end else begin
            r_hs_prev <= bus.IN_HSYNC;
            r_vs_prev <= bus.IN_VSYNC;
            r_x       <= w_x + 10'd1;
            r_y       <= w_y;
        end
    end
`else
    assign w_thresh = 4'd0;
`endif

    // Stage 1: capture colour, syncs and the threshold for this pixel.
    logic [7:0] r_s1_red;
    logic [7:0] r_s1_green;
    logic [7:0] r_s1_blue;
    logic       r_s1_hsync;
    logic       r_s1_vsync;
    logic [3:0] r_s1_thresh;

    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            r_s1_red    <= 8'd0;
            r_s1_green  <= 8'd0;
            r_s1_blue   <= 8'd0;
            r_s1_hsync  <= c_SYNC_IDLE;
            r_s1_vsync  <= c_SYNC_IDLE;
            r_s1_thresh <= 4'd0;
        end else begin
            r_s1_red    <= bus.IN_RED;
            r_s1_green  <= bus.IN_GREEN;
            r_s1_blue   <= bus.IN_BLUE;
            r_s1_hsync  <= bus.IN_HSYNC;
            r_s1_vsync  <= bus.IN_VSYNC;
            r_s1_thresh <= w_thresh;
        end
    end

    // Stage 2: saturated, truncated colour and syncs delayed to match.
    logic [3:0] r_out_red;
    logic [3:0] r_out_green;
    logic [3:0] r_out_blue;
    logic       r_out_hsync;
    logic       r_out_vsync;

    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            r_out_red   <= 4'd0;
            r_out_green <= 4'd0;
            r_out_blue  <= 4'd0;
            r_out_hsync <= c_SYNC_IDLE;
            r_out_vsync <= c_SYNC_IDLE;
        end else begin
            r_out_red   <= sat_trunc(r_s1_red,   r_s1_thresh);
            r_out_green <= sat_trunc(r_s1_green, r_s1_thresh);
            r_out_blue  <= sat_trunc(r_s1_blue,  r_s1_thresh);
            r_out_hsync <= r_s1_hsync;
            r_out_vsync <= r_s1_vsync;
        end
    end

    assign bus.VGA_RED   = r_out_red;
    assign bus.VGA_GREEN = r_out_green;
    assign bus.VGA_BLUE  = r_out_blue;
    assign bus.VGA_HSYNC = r_out_hsync;
    assign bus.VGA_VSYNC = r_out_vsync;

endmodule

`default_nettype wire

// File: tb/tb_vga_dither.sv
// ============================================================================
// Module      : tb_vga_dither
// Description : Scoreboard bench for vga_dither; reference model follows the
//               VGA_DITHER_EN macro the same way the design build does.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_dither;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #20 clk = ~clk;

    vga_dither_if bus();

    vga_dither #(.SYNC_ACTIVE_LOW(1'b1)) dut (
        .CLK_25MHZ (clk),
        .RESET     (rst),
        .bus       (bus)
    );

    typedef struct {
        int         due;
        logic       hs;
        logic       vs;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } exp_t;

    exp_t q[$];
    exp_t e_m;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model state: previous sync levels and current screen position.
    logic m_hprev;
    logic m_vprev;
    int   mx;
    int   my;
`ifdef VGA_DITHER_EN
    int bayer[4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
`endif

    always @(posedge clk) cyc++;

    function automatic logic [3:0] ref_chan(input int c, input int t);
        int s;
        s = c + t;
        if (s > 255) s = 255;
        return 4'(s / 16);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_hprev = 1'b1;
        m_vprev = 1'b1;
        mx      = 0;
        my      = 0;
    endtask

    // Present one pixel now and record what must appear two cycles later.
    task automatic apply(input logic h, input logic v, input logic [7:0] r,
                         input logic [7:0] g, input logic [7:0] b);
        exp_t e;
        int   t;
        bit   hs_start;
        bit   vs_start;
        bus.IN_HSYNC = h;
        bus.IN_VSYNC = v;
        bus.IN_RED   = r;
        bus.IN_GREEN = g;
        bus.IN_BLUE  = b;
        hs_start = (h == 1'b0) && (m_hprev == 1'b1);
        vs_start = (v == 1'b0) && (m_vprev == 1'b1);
        if (hs_start) mx = 0;
        if (vs_start) my = 0;
        else if (hs_start) my = (my + 1) % 1024;
`ifdef VGA_DITHER_EN
        t = bayer[my % 4][mx % 4];
`else
        t = 0;
`endif
        e.due = cyc + 2;
        e.hs  = h;
        e.vs  = v;
        e.r   = ref_chan(int'(r), t);
        e.g   = ref_chan(int'(g), t);
        e.b   = ref_chan(int'(b), t);
        q.push_back(e);
        mx      = (mx + 1) % 1024;
        m_hprev = h;
        m_vprev = v;
    endtask

    task automatic drive(input logic h, input logic v, input logic [7:0] r,
                         input logic [7:0] g, input logic [7:0] b);
        @(posedge clk);
        #1;
        apply(h, v, r, g, b);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_red"},   {4'h0, bus.VGA_RED},   8'h00);
        chk({tag, "_green"}, {4'h0, bus.VGA_GREEN}, 8'h00);
        chk({tag, "_blue"},  {4'h0, bus.VGA_BLUE},  8'h00);
        chk({tag, "_hsync"}, {7'h0, bus.VGA_HSYNC}, 8'h01);
        chk({tag, "_vsync"}, {7'h0, bus.VGA_VSYNC}, 8'h01);
    endtask

    // Assert reset between edges, hold it with random inputs, release cleanly.
    task automatic do_reset(input int hold);
        @(posedge clk);
        #5;
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_async");
        q.delete();
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            bus.IN_HSYNC = 1'($urandom);
            bus.IN_VSYNC = 1'($urandom);
            bus.IN_RED   = 8'($urandom);
            bus.IN_GREEN = 8'($urandom);
            bus.IN_BLUE  = 8'($urandom);
            @(negedge clk);
            chk_reset_vals("rst_hold");
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        apply(1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    endtask

    // One short line: 2-cycle hsync pulse then 12 pixels of the chosen pattern.
    task automatic line(input int kind, input bit vs_pulse);
        logic [7:0] c;
        for (int i = 0; i < 2; i++) drive(1'b0, vs_pulse ? 1'b0 : 1'b1, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 12; i++) begin
            case (kind)
                0: c = 8'h18;
                1: c = 8'h00;
                2: c = 8'hFF;
                3: c = 8'h07;
                4: c = 8'hF7;
                default: c = 8'($urandom);
            endcase
            if (kind >= 5) drive(1'b1, 1'b1, c, 8'($urandom), 8'($urandom));
            else           drive(1'b1, 1'b1, c, c, c);
        end
    endtask

    // Monitor: pops whenever an expected pixel is due at the outputs.
    always @(negedge clk) begin
        if (!rst) begin
            while (q.size() > 0 && q[0].due < cyc) begin
                e_m = q.pop_front();
                checks++;
                errors++;
                $display("FAIL overdue actual=missed expected=due_cycle_%0d", e_m.due);
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                e_m = q.pop_front();
                chk("out_hsync", {7'h0, bus.VGA_HSYNC}, {7'h0, e_m.hs});
                chk("out_vsync", {7'h0, bus.VGA_VSYNC}, {7'h0, e_m.vs});
                chk("out_red",   {4'h0, bus.VGA_RED},   {4'h0, e_m.r});
                chk("out_green", {4'h0, bus.VGA_GREEN}, {4'h0, e_m.g});
                chk("out_blue",  {4'h0, bus.VGA_BLUE},  {4'h0, e_m.b});
            end
        end
    end

    initial begin
        bus.IN_HSYNC = 1'b1;
        bus.IN_VSYNC = 1'b1;
        bus.IN_RED   = 8'h00;
        bus.IN_GREEN = 8'h00;
        bus.IN_BLUE  = 8'h00;
        model_reset();
        #2;
        do_reset(4);

        // Latency: lone red pixel and a 3-cycle hsync pulse amid idle pixels.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        drive(1'b1, 1'b1, 8'hFF, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 8'h00, 8'h00, 8'h00);

        // Frame start with coincident vsync/hsync, then the directed patterns.
        line(0, 1'b1);
        for (int i = 0; i < 4; i++) line(0, 1'b0);
        line(1, 1'b0);
        line(2, 1'b0);
        line(3, 1'b1);
        for (int i = 0; i < 4; i++) line(3, 1'b0);
        line(4, 1'b0);
        for (int i = 0; i < 6; i++) line(5, (i == 3));

        // Long stretch without hsync so the column counter wraps.
        for (int i = 0; i < 1100; i++)
            drive(1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
        line(3, 1'b0);

        do_reset(3);
        for (int i = 0; i < 4; i++) line(5, (i == 0));

        // Random sync activity, biased towards the inactive level.
        for (int i = 0; i < 400; i++)
            drive(($urandom_range(0, 5) != 0), ($urandom_range(0, 19) != 0),
                  8'($urandom), 8'($urandom), 8'($urandom));

        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d_pending expected=0_pending", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
